ascon_serial_io: RTL and testbench
==================================

# ascon_serial_io

Parametrised serial front/back end for the Ascon encryption core. It deserialises key, nonce, associated data and plaintext from W-bit-per-cycle lanes under a valid/ready handshake and presents them in parallel to the core. It issues a one-cycle start, captures ciphertext and tag when the core reports ready, and serialises them back out under a second valid/ready handshake. It supports back-to-back operations without reset.

## Interface
Parameters:
- `K`, 128, key length in bits
- `L`, 40, associated-data length in bits
- `Y`, 40, plaintext/ciphertext length in bits
- `W`, 1, lane width in bits per beat; one of 1,2,4,8,16,32,64. K, L, Y and 128 must be multiples of W (elaboration error otherwise).

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `keyxSI`, `noncexSI`, `associated_dataxSI`, `plain_textxSI`  in  W  input lanes, MSB-first
- `in_validxSI`  in  1  input beat valid
- `in_readyxSO`  out  1  input beat accepted when high with valid
- `keyxSO`  out  K, `noncexSO`  out  128, `associated_dataxSO`  out  L, `plain_textxSO`  out  Y  parallel operands to core
- `encryption_startxSO`  out  1  one-cycle start pulse to core
- `encryption_readyxSI`  in  1  core done
- `cipher_textxSI`  in  Y, `tagxSI`  in  128  core results
- `cipher_textxSO`, `tagxSO`  out  W  output lanes, LSB-first
- `out_validxSO`  out  1  output beat valid
- `out_readyxSI`  in  1  output beat consumed

## Operation
- Derived quantities: IN_BEATS = max(K,L,Y,128)/W and OUT_BEATS = max(Y,128)/W. Beat counter width is clog2(max(IN_BEATS,OUT_BEATS)+1).
- FSM states: LOAD, START, WAIT, UNLOAD. Reset goes to LOAD.
- LOAD:
  - in_readyxSO=1.
  - Per accepted beat, each channel whose length is not yet filled shifts its lane into its LSB end. The first beat lands in the MSBs.
  - A channel ignores beats once it holds LEN/W beats.
  - The accepted beat with count IN_BEATS-1 moves the FSM to START.
- START: encryption_startxSO=1 for exactly one cycle, then WAIT.
- WAIT:
  - encryption_readyxSI is sampled only in this state.
  - When it is high, the block loads cipher_textxSI and tagxSI into the output shift registers and moves to UNLOAD.
- UNLOAD:
  - out_validxSO=1. Each lane presents bit range [W-1:0] of its register.
  - On out_valid && out_ready, both registers shift right by W. Bits beyond a channel's length read 0.
  - Data is held stable while valid and not ready.
  - The handshake with count OUT_BEATS-1 moves the FSM to LOAD.
- Parallel operand outputs hold their values from the last LOAD beat until the next accepted LOAD beat; they never change in START/WAIT/UNLOAD.
- Input-side beats outside LOAD are not accepted (in_ready=0); lane values are don't-care.
- Reset at any point, including mid-load or mid-unload: all registers and counters clear, the FSM returns to LOAD and partial data is discarded.

## Timing
- Reset values: in_readyxSO=0 while rst high, 1 from the first cycle after release. All other outputs are 0, including the parallel operands, start, out_valid and the lanes.
- Start latency: encryption_startxSO is high in the cycle after the last input handshake.
- Capture latency: out_validxSO rises in the cycle after encryption_readyxSI is seen high in WAIT.
- Turnaround: in_readyxSO rises in the cycle after the last output handshake.
- Zero bubbles: with in_valid held high, a full load takes exactly IN_BEATS cycles. With out_ready held high, a full unload takes exactly OUT_BEATS cycles.
- encryption_readyxSI high during START is ignored (stale ready from the previous operation).

## Structure
- Package `ascon_io_pkg`: FSM state enum, constant function `max4` for beat counts, legal-W check function.
- Sub-module `ascon_sipo_lane`: parametrised by LEN and W, with shift enable and fill-count cutoff. It is instantiated four times. The output side is plain shift registers in the top.
- Target size: about 200 lines of RTL.

## Test plan
- W=1, K=128, L=40, Y=40:
  - Stimulus: key 2db083053e848cefa30007336c47a5a1, nonce 3f3607dbce3503ba84f5843d623de056, AD 4153434f4e, PT 6173636f6e.
  - Required: after 128 beats, parallel outputs equal these values and start pulses exactly once.
- Same W=1 setup with a stub core that returns CT 0123456789 and tag fedcba98765432100011223344556677 two cycles after start:
  - Required: 128 output beats. Ciphertext lane bits 0..39 equal CT LSB-first (first bit 1), then 0. Tag lane first bit 1.
- W=8, same vectors:
  - Required: 16 input beats; output beat 0 shows ciphertext 0x89 and tag 0x77; beats 5..15 on the ciphertext lane read 0x00.
- Random in_valid gaps and out_ready stalls at W=4:
  - Required: identical results.
  - Lanes are held stable during stalls. No beat is accepted outside LOAD.
- Reset asserted at input beat 60, then a full reload:
  - Required: outputs are 0 during reset. The new operation's parallel values contain no residue from the aborted load.
- Two back-to-back operations, the second with AD 0000000001, and core ready left high between them:
  - Required: the second start fires only after the full reload.
  - Stale ready in START is ignored, and the second results are output correctly.

Source files
------------

// File: rtl/ascon_io_pkg.sv
// Shared types and elaboration-time helpers for the Ascon serial front/back end.
// Holds the FSM state encoding, beat-count arithmetic and the lane-width legality check.
package ascon_io_pkg;

    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} ioState_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic bit legalW(input int w, input int k, input int l, input int y);
        bit pow2;
        pow2 = (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32) || (w == 64);
        return pow2 && (k % w == 0) && (l % w == 0) && (y % w == 0) && (128 % w == 0);
    endfunction

endpackage

// File: rtl/ascon_sipo_lane.sv
// Serial-in parallel-out lane: shifts W bits into the LSB end per enabled beat, MSB-first.
// Zero latency to dataOut after the shifting edge; stops accepting once LEN/W beats are held.
module ascon_sipo_lane #(
    parameter int LEN = 40,
    parameter int W   = 1,
    parameter int CW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           shiftEn,
    input  logic [CW-1:0]  beatCnt,
    input  logic [W-1:0]   laneIn,
    output logic [LEN-1:0] dataOut
);

    localparam logic [CW-1:0] FILL = CW'(LEN / W);

    logic [LEN-1:0] shiftReg;

    // Shorter channels ride along with the shared beat counter and simply stop when full.
    if (LEN == W) begin : gSingle
        always_ff @(posedge clk) begin
            if (rst) begin
                shiftReg <= '0;
            end else if (shiftEn && (beatCnt < FILL)) begin
                shiftReg <= laneIn;
            end
        end
    end else begin : gShift
        always_ff @(posedge clk) begin
            if (rst) begin
                shiftReg <= '0;
            end else if (shiftEn && (beatCnt < FILL)) begin
                shiftReg <= {shiftReg[LEN-W-1:0], laneIn};
            end
        end
    end

    assign dataOut = shiftReg;

endmodule

// File: rtl/ascon_serial_io.sv
// Serial front/back end for the Ascon core: deserialise operands, pulse start, serialise CT/tag LSB-first.
// Start follows the last input beat by one cycle; both sides stall cleanly on valid/ready without bubbles.
module ascon_serial_io
    import ascon_io_pkg::*;
#(
    parameter int K = 128,
    parameter int L = 40,
    parameter int Y = 40,
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   keyxSI,
    input  logic [W-1:0]   noncexSI,
    input  logic [W-1:0]   associated_dataxSI,
    input  logic [W-1:0]   plain_textxSI,
    input  logic           in_validxSI,
    output logic           in_readyxSO,
    output logic [K-1:0]   keyxSO,
    output logic [127:0]   noncexSO,
    output logic [L-1:0]   associated_dataxSO,
    output logic [Y-1:0]   plain_textxSO,
    output logic           encryption_startxSO,
    input  logic           encryption_readyxSI,
    input  logic [Y-1:0]   cipher_textxSI,
    input  logic [127:0]   tagxSI,
    output logic [W-1:0]   cipher_textxSO,
    output logic [W-1:0]   tagxSO,
    output logic           out_validxSO,
    input  logic           out_readyxSI
);

    localparam int IN_BEATS  = max4(K, L, Y, 128) / W;
    localparam int OUT_BEATS = max4(Y, 128, 0, 0) / W;
    localparam int CW        = $clog2(max4(IN_BEATS, OUT_BEATS, 0, 0) + 1);
    localparam logic [CW-1:0] IN_LAST  = CW'(IN_BEATS - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BEATS - 1);

    if (!legalW(W, K, L, Y)) begin : gBadW
        $error("ascon_serial_io: W must be 1..64, a power of two, dividing K, L, Y and 128");
    end

    ioState_t       state;
    ioState_t       stateNext;
    logic [CW-1:0]  beatCnt;
    logic [Y-1:0]   ctReg;
    logic [127:0]   tagReg;
    logic           inAccept;
    logic           outAccept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext           = state;
        in_readyxSO         = 1'b0;
        encryption_startxSO = 1'b0;
        out_validxSO        = 1'b0;
        case (state)
            LOAD: begin
                // Gated by rst so the input side never looks ready while held in reset.
                in_readyxSO = !rst;
                if (in_validxSI && !rst && (beatCnt == IN_LAST)) stateNext = START;
            end
            START: begin
                encryption_startxSO = 1'b1;
                stateNext           = WAIT;
            end
            WAIT: begin
                if (encryption_readyxSI) stateNext = UNLOAD;
            end
            UNLOAD: begin
                out_validxSO = 1'b1;
                if (out_readyxSI && (beatCnt == OUT_LAST)) stateNext = LOAD;
            end
            default: stateNext = LOAD;
        endcase
    end

    assign inAccept  = in_validxSI && in_readyxSO;
    assign outAccept = out_validxSO && out_readyxSI;

    // One counter serves both directions; it is always zero on entry to LOAD and UNLOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            beatCnt <= '0;
        end else if ((inAccept && (beatCnt == IN_LAST)) || (outAccept && (beatCnt == OUT_LAST))) begin
            beatCnt <= '0;
        end else if (inAccept || outAccept) begin
            beatCnt <= beatCnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctReg  <= '0;
            tagReg <= '0;
        end else if ((state == WAIT) && encryption_readyxSI) begin
            ctReg  <= cipher_textxSI;
            tagReg <= tagxSI;
        end else if (outAccept) begin
            ctReg  <= ctReg >> W;
            tagReg <= tagReg >> W;
        end
    end

    assign cipher_textxSO = ctReg[W-1:0];
    assign tagxSO         = tagReg[W-1:0];

    ascon_sipo_lane #(.LEN(K), .W(W), .CW(CW)) uKey (
        .clk(clk), .rst(rst), .shiftEn(inAccept), .beatCnt(beatCnt),
        .laneIn(keyxSI), .dataOut(keyxSO)
    );

    ascon_sipo_lane #(.LEN(128), .W(W), .CW(CW)) uNonce (
        .clk(clk), .rst(rst), .shiftEn(inAccept), .beatCnt(beatCnt),
        .laneIn(noncexSI), .dataOut(noncexSO)
    );

    ascon_sipo_lane #(.LEN(L), .W(W), .CW(CW)) uAd (
        .clk(clk), .rst(rst), .shiftEn(inAccept), .beatCnt(beatCnt),
        .laneIn(associated_dataxSI), .dataOut(associated_dataxSO)
    );

    ascon_sipo_lane #(.LEN(Y), .W(W), .CW(CW)) uPt (
        .clk(clk), .rst(rst), .shiftEn(inAccept), .beatCnt(beatCnt),
        .laneIn(plain_textxSI), .dataOut(plain_textxSO)
    );

endmodule

// File: tb/tb_ascon_serial_io.sv
// Bench for ascon_serial_io at lane widths 1, 8 and 4 (the last with random input gaps and output stalls).
// Each width runs: reset, a full operation, an aborted load plus reload, and two back-to-back operations.
module tb_ascon_serial_io;

    localparam logic [127:0] KEY_V   = 128'h2db083053e848cefa30007336c47a5a1;
    localparam logic [127:0] NONCE_V = 128'h3f3607dbce3503ba84f5843d623de056;
    localparam logic [127:0] AD_V    = 128'h4153434f4e;
    localparam logic [127:0] AD2_V   = 128'h0000000001;
    localparam logic [127:0] PT_V    = 128'h6173636f6e;
    localparam logic [39:0]  CT_V    = 40'h0123456789;
    localparam logic [127:0] TAG_V   = 128'hfedcba98765432100011223344556677;
    localparam logic [39:0]  CT2_V   = 40'ha5a5c3c35a;
    localparam logic [127:0] TAG2_V  = 128'h00112233445566778899aabbccddeeff;

    localparam int P_LOAD   = 0;
    localparam int P_START  = 1;
    localparam int P_WAIT   = 2;
    localparam int P_UNLOAD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int w, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (W=%0d) @%0t: got %h expected %h", nm, w, $time, act, exp);
        end
    endtask

    function automatic logic [127:0] lenMask(input int len);
        return (len >= 128) ? {128{1'b1}} : ((128'd1 << len) - 128'd1);
    endfunction

    // Value a channel of length len must show after n beats of nv, starting from old contents base.
    function automatic logic [127:0] fillExp(input logic [127:0] base, input logic [127:0] nv,
                                             input int n, input int len, input int w);
        int b;
        b = n * w;
        if (b > len) b = len;
        if (b == 0) return base;
        return ((base << b) | (nv >> (len - b))) & lenMask(len);
    endfunction

    function automatic logic [127:0] laneAt(input logic [127:0] v, input int m, input int w);
        return (v >> (m * w)) & lenMask(w);
    endfunction

    function automatic logic [63:0] inBeat(input logic [127:0] v, input int len, input int n, input int w);
        if (n < len / w) return 64'((v >> (len - (n + 1) * w)) & lenMask(w));
        return {$urandom, $urandom};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gW
        localparam int TW        = (g == 0) ? 1 : (g == 1) ? 8 : 4;
        localparam bit STALL     = (g == 2);
        localparam int IN_BEATS  = 128 / TW;
        localparam int OUT_BEATS = 128 / TW;
        localparam int ABORT_AT  = (TW == 1) ? 60 : IN_BEATS / 2;
        localparam logic [127:0] CT_FIRST  = (TW == 1) ? 128'h1 : (TW == 8) ? 128'h89 : 128'h9;
        localparam logic [127:0] TAG_FIRST = (TW == 1) ? 128'h1 : (TW == 8) ? 128'h77 : 128'h7;

        logic           rst = 1'b1;
        logic [TW-1:0]  keyL = '0, nonceL = '0, adL = '0, ptL = '0;
        logic           inValid = 1'b0, inReady;
        logic [127:0]   keyP, nonceP;
        logic [39:0]    adP, ptP;
        logic           start, encReady, outValid, outReady;
        logic [39:0]    ctIn = '0;
        logic [127:0]   tagIn = '0;
        logic [TW-1:0]  ctL, tagL;

        logic [127:0]   opKey = '0, opNonce = '0, opAd = '0, opPt = '0;
        logic [127:0]   bKey = '0, bNonce = '0, bAd = '0, bPt = '0, capCt = '0, capTag = '0;
        logic [127:0]   keyAtStart = '0, nonceAtStart = '0, adAtStart = '0, ptAtStart = '0;
        logic [127:0]   firstCt = '0, firstTag = '0;
        int             mPhase = P_LOAD, nIn = 0, nOut = 0, opsDone = 0, startCount = 0;
        bit             mValid = 1'b0, keepReady = 1'b0, done = 1'b0;

        ascon_serial_io #(.K(128), .L(40), .Y(40), .W(TW)) dut (
            .clk(clk), .rst(rst),
            .keyxSI(keyL), .noncexSI(nonceL), .associated_dataxSI(adL), .plain_textxSI(ptL),
            .in_validxSI(inValid), .in_readyxSO(inReady),
            .keyxSO(keyP), .noncexSO(nonceP), .associated_dataxSO(adP), .plain_textxSO(ptP),
            .encryption_startxSO(start), .encryption_readyxSI(encReady),
            .cipher_textxSI(ctIn), .tagxSI(tagIn),
            .cipher_textxSO(ctL), .tagxSO(tagL),
            .out_validxSO(outValid), .out_readyxSI(outReady)
        );

        // Behavioural model and per-cycle compare; advances on what happens at the next rising edge.
        initial begin
            forever begin
                @(negedge clk);
                if (mValid) begin
                    chk("in_ready", TW, 128'(inReady), 128'(mPhase == P_LOAD && !rst));
                    chk("start", TW, 128'(start), 128'(mPhase == P_START));
                    chk("out_valid", TW, 128'(outValid), 128'(mPhase == P_UNLOAD));
                    chk("ct_lane", TW, 128'(ctL), (mPhase == P_UNLOAD) ? laneAt(capCt, nOut, TW) : 128'd0);
                    chk("tag_lane", TW, 128'(tagL), (mPhase == P_UNLOAD) ? laneAt(capTag, nOut, TW) : 128'd0);
                    chk("key_par", TW, keyP, fillExp(bKey, opKey, nIn, 128, TW));
                    chk("nonce_par", TW, nonceP, fillExp(bNonce, opNonce, nIn, 128, TW));
                    chk("ad_par", TW, 128'(adP), fillExp(bAd, opAd, nIn, 40, TW));
                    chk("pt_par", TW, 128'(ptP), fillExp(bPt, opPt, nIn, 40, TW));
                    if (mPhase == P_UNLOAD && nOut == 0) begin
                        firstCt  = 128'(ctL);
                        firstTag = 128'(tagL);
                    end
                    if (start === 1'b1) begin
                        startCount++;
                        keyAtStart   = keyP;
                        nonceAtStart = nonceP;
                        adAtStart    = 128'(adP);
                        ptAtStart    = 128'(ptP);
                    end
                end
                if (rst) begin
                    mPhase = P_LOAD; nIn = 0; nOut = 0;
                    bKey = '0; bNonce = '0; bAd = '0; bPt = '0; capCt = '0; capTag = '0;
                    mValid = 1'b1;
                end else begin
                    case (mPhase)
                        P_LOAD: if (inValid) begin
                            nIn++;
                            if (nIn == IN_BEATS) mPhase = P_START;
                        end
                        P_START: mPhase = P_WAIT;
                        P_WAIT: if (encReady) begin
                            capCt  = 128'(ctIn);
                            capTag = tagIn;
                            nOut   = 0;
                            mPhase = P_UNLOAD;
                        end
                        default: if (outReady) begin
                            nOut++;
                            if (nOut == OUT_BEATS) begin
                                bKey   = fillExp(bKey, opKey, IN_BEATS, 128, TW);
                                bNonce = fillExp(bNonce, opNonce, IN_BEATS, 128, TW);
                                bAd    = fillExp(bAd, opAd, IN_BEATS, 40, TW);
                                bPt    = fillExp(bPt, opPt, IN_BEATS, 40, TW);
                                nIn    = 0;
                                mPhase = P_LOAD;
                                opsDone++;
                            end
                        end
                    endcase
                end
            end
        end

        // Stub core: ready two cycles after start, dropped once results are being unloaded.
        initial begin
            encReady = 1'b0;
            forever begin
                @(negedge clk);
                if (start === 1'b1) begin
                    repeat (2) @(posedge clk);
                    #1 encReady = 1'b1;
                    if (!keepReady) begin
                        for (int c = 0; c < 50 && outValid !== 1'b1; c++) begin
                            @(posedge clk);
                            #1;
                        end
                        encReady = 1'b0;
                    end
                end
            end
        end

        initial begin
            outReady = 1'b0;
            forever begin
                @(posedge clk);
                #1 outReady = STALL ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end

        task automatic setOp(input logic [127:0] k, input logic [127:0] nn, input logic [127:0] a,
                             input logic [127:0] p, input logic [39:0] ct, input logic [127:0] tg);
            opKey = k; opNonce = nn; opAd = a; opPt = p; ctIn = ct; tagIn = tg;
            startCount = 0;
        endtask

        task automatic loadOp(input int abortAt);
            int  n;
            int  cyc;
            bit  acc;
            n = 0;
            cyc = 0;
            while (n < IN_BEATS && cyc < 4 * IN_BEATS + 50 && !(abortAt >= 0 && n == abortAt)) begin
                if (STALL && $urandom_range(0, 3) == 0) begin
                    inValid = 1'b0;
                    keyL = TW'($urandom); nonceL = TW'($urandom); adL = TW'($urandom); ptL = TW'($urandom);
                end else begin
                    inValid = 1'b1;
                    keyL   = TW'(inBeat(opKey, 128, n, TW));
                    nonceL = TW'(inBeat(opNonce, 128, n, TW));
                    adL    = TW'(inBeat(opAd, 40, n, TW));
                    ptL    = TW'(inBeat(opPt, 40, n, TW));
                end
                @(negedge clk);
                acc = inValid && inReady;
                @(posedge clk);
                #1;
                cyc++;
                if (acc) n++;
            end
            if (abortAt >= 0 && n == abortAt) begin
                inValid = 1'b0;
                rst = 1'b1;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                @(negedge clk);
                chk("abort_key_zero", TW, keyP, 128'd0);
                chk("abort_in_ready_low", TW, 128'(inReady), 128'd0);
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                chk("load_beats", TW, 128'(n), 128'(IN_BEATS));
                if (!STALL) chk("load_cycles", TW, 128'(cyc), 128'(IN_BEATS));
                // Junk beats offered while the core runs must not be taken.
                inValid = 1'b1;
                keyL = TW'($urandom); nonceL = TW'($urandom); adL = TW'($urandom); ptL = TW'($urandom);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                inValid = 1'b0;
            end
        endtask

        task automatic waitOps(input int k);
            int c;
            c = 0;
            while (opsDone < k && c < 3000) begin
                @(posedge clk);
                c++;
            end
            #1;
            chk("op_complete", TW, 128'(opsDone), 128'(k));
        endtask

        initial begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("reset_in_ready", TW, 128'(inReady), 128'd0);
            chk("reset_key", TW, keyP, 128'd0);
            chk("reset_out_valid", TW, 128'(outValid), 128'd0);
            @(posedge clk);
            #1 rst = 1'b0;

            setOp(KEY_V, NONCE_V, AD_V, PT_V, CT_V, TAG_V);
            loadOp(-1);
            waitOps(1);
            chk("opA_starts", TW, 128'(startCount), 128'd1);
            chk("opA_key", TW, keyAtStart, KEY_V);
            chk("opA_nonce", TW, nonceAtStart, NONCE_V);
            chk("opA_ad", TW, adAtStart, AD_V);
            chk("opA_pt", TW, ptAtStart, PT_V);
            chk("opA_ct_beat0", TW, firstCt, CT_FIRST);
            chk("opA_tag_beat0", TW, firstTag, TAG_FIRST);

            setOp(KEY_V, NONCE_V, AD_V, PT_V, CT_V, TAG_V);
            loadOp(ABORT_AT);
            startCount = 0;
            loadOp(-1);
            waitOps(2);
            chk("reload_starts", TW, 128'(startCount), 128'd1);
            chk("reload_key", TW, keyAtStart, KEY_V);
            chk("reload_ad", TW, adAtStart, AD_V);

            keepReady = 1'b1;
            setOp(KEY_V, NONCE_V, AD_V, PT_V, CT_V, TAG_V);
            loadOp(-1);
            waitOps(3);
            chk("b2b1_starts", TW, 128'(startCount), 128'd1);
            setOp(KEY_V, NONCE_V, AD2_V, PT_V, CT2_V, TAG2_V);
            loadOp(-1);
            waitOps(4);
            chk("b2b2_starts", TW, 128'(startCount), 128'd1);
            chk("b2b2_ad", TW, adAtStart, AD2_V);
            chk("b2b2_key", TW, keyAtStart, KEY_V);
            done = 1'b1;
        end
    end

    initial begin
        int c;
        c = 0;
        while (c < 60000 && !(gW[0].done && gW[1].done && gW[2].done)) begin
            @(posedge clk);
            c++;
        end
        chk("all_widths_done", 0, {125'd0, gW[2].done, gW[1].done, gW[0].done}, 128'd7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
